psg_write_sequencer: RTL



---
 rtl/psg_pkg.sv | 31 +++
 rtl/psg_sync_fifo.sv | 57 +++++
 rtl/psg_write_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared PSG definitions: register map, bus widths and the write-request record.
package psg_pkg;

    localparam int PSG_NUM_REGS = 16;
    localparam int PSG_ADDR_W   = 4;
    localparam int PSG_DATA_W   = 8;

    // PSG register indices
    localparam logic [PSG_ADDR_W-1:0] R_TONE_A_FINE   = 4'd0;
    localparam logic [PSG_ADDR_W-1:0] R_TONE_A_COARSE = 4'd1;
    localparam logic [PSG_ADDR_W-1:0] R_TONE_B_FINE   = 4'd2;
    localparam logic [PSG_ADDR_W-1:0] R_TONE_B_COARSE = 4'd3;
    localparam logic [PSG_ADDR_W-1:0] R_TONE_C_FINE   = 4'd4;
    localparam logic [PSG_ADDR_W-1:0] R_TONE_C_COARSE = 4'd5;
    localparam logic [PSG_ADDR_W-1:0] R_NOISE_PERIOD  = 4'd6;
    localparam logic [PSG_ADDR_W-1:0] R_MIXER         = 4'd7;
    localparam logic [PSG_ADDR_W-1:0] R_AMP_A         = 4'd8;
    localparam logic [PSG_ADDR_W-1:0] R_AMP_B         = 4'd9;
    localparam logic [PSG_ADDR_W-1:0] R_AMP_C         = 4'd10;
    localparam logic [PSG_ADDR_W-1:0] R_ENV_FINE      = 4'd11;
    localparam logic [PSG_ADDR_W-1:0] R_ENV_COARSE    = 4'd12;
    localparam logic [PSG_ADDR_W-1:0] R_ENV_SHAPE     = 4'd13;
    localparam logic [PSG_ADDR_W-1:0] R_IO_A          = 4'd14;
    localparam logic [PSG_ADDR_W-1:0] R_IO_B          = 4'd15;

    typedef struct packed {
        logic [PSG_ADDR_W-1:0] addr;
        logic [PSG_DATA_W-1:0] data;
    } psg_write_t;

endpackage

// File: rtl/psg_sync_fifo.sv
// Single-clock request FIFO. Push is refused when full and pop when empty,
// so callers may present push/pop unconditionally. DEPTH must be a power of 2.
module psg_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LVL_W'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/psg_write_sequencer.sv
// PSG write sequencer: queues (register, value) requests and plays them onto
// the PSG's shared 8-bit input as address-phase / data-phase pairs, tracking
// the PSG latch toggle and keeping a shadow copy of all PSG registers.
module psg_write_sequencer
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_BITS-1:0]            req_addr,
    input  logic [DATA_BITS-1:0]            req_data,
    output logic [DATA_BITS-1:0]            bus_data,
    output logic                            phase,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    input  logic [ADDR_BITS-1:0]            rd_addr,
    output logic [DATA_BITS-1:0]            rd_data
);

    localparam int ENT_W = ADDR_BITS + DATA_BITS;

    logic [ENT_W-1:0]     fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [DATA_BITS-1:0] cur_data;
    logic [ADDR_BITS-1:0] next_addr;
    logic [DATA_BITS-1:0] next_data;
    logic                 pending;
    logic [DATA_BITS-1:0] shadow [PSG_NUM_REGS];

    // A new write is taken only at the edge that leaves the data phase, so the
    // following address phase already carries it. With nothing queued the
    // current pair is replayed; rewriting an identical value is invisible.
    assign push      = req_valid && !fifo_full;
    assign pop       = !phase && !fifo_empty;
    assign {next_addr, next_data} = pop ? fifo_head : {cur_addr, cur_data};
    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || pending;
    assign rd_data   = shadow[rd_addr];

    psg_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Phase tracker, current transaction and bus driver, in lock-step with the PSG latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= 1'b0;
            cur_addr <= '0;
            cur_data <= '0;
            pending  <= 1'b0;
            bus_data <= '0;
        end else begin
            phase <= !phase;
            if (!phase) begin
                cur_addr <= next_addr;
                cur_data <= next_data;
                pending  <= pop;
                bus_data <= DATA_BITS'(next_addr);
            end else begin
                bus_data <= cur_data;
            end
        end
    end

    // Shadow register file: mirrors the PSG's write at the end of each data phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PSG_NUM_REGS; i++) shadow[i] <= '0;
        end else if (!phase) begin
            shadow[cur_addr] <= cur_data;
        end
    end

endmodule
